// File: rtl/vga_multi_sprite.sv
// VGA sync generator driving N_OBJ independently bouncing square sprites.
// Buttons pause motion, select a sprite, and reverse the selected sprite's X or Y direction.
module vga_multi_sprite #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned N_OBJ     = 4,
  parameter int unsigned OBJ_SIZE  = 16,
  parameter int unsigned STEP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] push,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SEL_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_OBJ - 1);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0]  V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0]  HS_BEG = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
  localparam logic [9:0]  SIZE   = 10'(OBJ_SIZE);
  localparam logic [9:0]  STP    = 10'(STEP);
  localparam logic [10:0] SIZE_W = 11'(OBJ_SIZE);
  localparam logic [10:0] STP_W  = 11'(STEP);
  localparam logic [10:0] H_LIM  = 11'(H_DISPLAY);
  localparam logic [10:0] V_LIM  = 11'(V_DISPLAY);

  logic [DIV_W-1:0]       div_q, div_d;
  logic [9:0]             h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [3:0]             push_q, push_edge;
  logic                   paused_q, paused_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [N_OBJ-1:0][9:0]  x_q, x_d, y_q, y_d;
  logic [N_OBJ-1:0]       dx_q, dx_d, dy_q, dy_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0]             rgb_q, rgb_d;
  logic                   p_tick, frame_tick, video_on, hit;
  logic [10:0]            nx, ny;

  // One axis step: returns {dir, pos}; dir=1 means increasing. 11-bit compare avoids wrap.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                         input logic [10:0] lim);
    logic [10:0] r;
    if (dir) begin
      if ({1'b0, pos} + SIZE_W + STP_W > lim) r = {1'b0, lim[9:0] - SIZE};
      else                                    r = {1'b1, pos + STP};
    end else begin
      if (pos < STP) r = {1'b1, 10'd0};
      else           r = {1'b0, pos - STP};
    end
    return r;
  endfunction

  assign p_tick     = (div_q == DIV_LAST);
  assign frame_tick = p_tick && (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);
  assign video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign push_edge  = push & ~push_q;

  always_comb begin
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (p_tick) begin
      div_d = '0;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Direction flips land before the frame move so a coincident press steers that move.
  always_comb begin
    paused_d = paused_q ^ push_edge[0];
    sel_d    = sel_q;
    if (push_edge[1]) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    nx   = '0;
    ny   = '0;
    if (push_edge[2]) dx_d[sel_q] = ~dx_q[sel_q];
    if (push_edge[3]) dy_d[sel_q] = ~dy_q[sel_q];
    if (frame_tick && !paused_q) begin
      for (int i = 0; i < N_OBJ; i++) begin
        nx      = bounce(x_q[i], dx_d[i], H_LIM);
        ny      = bounce(y_q[i], dy_d[i], V_LIM);
        x_d[i]  = nx[9:0];
        dx_d[i] = nx[10];
        y_d[i]  = ny[9:0];
        dy_d[i] = ny[10];
      end
    end
  end

  always_comb begin
    hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    rgb_d   = 3'b000;
    hit     = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!hit && (h_cnt_q >= x_q[i]) && ({1'b0, h_cnt_q} < {1'b0, x_q[i]} + SIZE_W) &&
          (v_cnt_q >= y_q[i]) && ({1'b0, v_cnt_q} < {1'b0, y_q[i]} + SIZE_W)) begin
        hit   = 1'b1;
        rgb_d = (SEL_W'(i) == sel_q) ? 3'b111 : 3'((i % 7) + 1);
      end
    end
    if (!video_on) rgb_d = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      push_q   <= '0;
      paused_q <= 1'b0;
      sel_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= 3'b000;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i]  <= 10'(32 + 64 * i);
        y_q[i]  <= 10'(32 + 48 * i);
        dx_q[i] <= (i % 2 == 0);
        dy_q[i] <= 1'b1;
      end
    end else begin
      div_q    <= div_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      push_q   <= push;
      paused_q <= paused_d;
      sel_q    <= sel_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      rgb_q    <= rgb_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_multi_sprite.sv
// Bench for vga_multi_sprite on a shrunken raster: a cycle-count based reference model
// predicts hsync/vsync/rgb every clock, plus probe tables and directed button sequences.
module tb_vga_multi_sprite;

  localparam int HD = 72, HFP = 2, HS = 4, HBP = 2;
  localparam int VD = 40, VFP = 1, VS = 2, VBP = 1;
  localparam int CD = 2, NO = 4, SZ = 8, ST = 4;
  localparam int HT = HD + HFP + HS + HBP;
  localparam int VT = VD + VFP + VS + VBP;
  localparam int FRAME = HT * VT * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] push = 4'b0000;
  logic       hsync, vsync;
  logic [2:0] rgb;

  vga_multi_sprite #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(CD), .N_OBJ(NO), .OBJ_SIZE(SZ), .STEP(ST)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } probe_t;

  int checks = 0;
  int errors = 0;

  // Reference model state; k counts clocks since the last reset edge.
  int         k;
  int         mx[NO], my[NO];
  bit         mdx[NO], mdy[NO];
  bit         mpaused;
  int         msel;
  logic [3:0] mprev;
  logic       exp_hs, exp_vs;
  logic [2:0] exp_rgb;
  int         hs_low, vs_low;

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NO; i++) begin
      mx[i] = 32 + 64 * i;
      my[i] = 32 + 48 * i;
      mdx[i] = (i % 2 == 0);
      mdy[i] = 1'b1;
    end
    mpaused = 1'b0;
    msel = 0;
    mprev = 4'b0000;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    exp_rgb = 3'b000;
    hs_low = 0;
    vs_low = 0;
  endtask

  function automatic logic [2:0] pix_colour(int h, int v);
    if (h >= HD || v >= VD) return 3'b000;
    for (int i = 0; i < NO; i++)
      if (h >= mx[i] && h < mx[i] + SZ && v >= my[i] && v < my[i] + SZ)
        return (i == msel) ? 3'b111 : 3'((i % 7) + 1);
    return 3'b000;
  endfunction

  task automatic move_axis(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + SZ + ST > lim) begin p = lim - SZ; d = 1'b0; end
      else p = p + ST;
    end else begin
      if (p < ST) begin p = 0; d = 1'b1; end
      else p = p - ST;
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic [3:0] push_v);
    int pix, h, v, p;
    bit tick, d;
    logic [3:0] e;
    if (rst_v) begin
      model_reset();
      return;
    end
    pix = (k / CD) % (HT * VT);
    h = pix % HT;
    v = pix / HT;
    tick = ((k % CD) == CD - 1);
    exp_hs = !(h >= HD + HFP && h < HD + HFP + HS);
    exp_vs = !(v >= VD + VFP && v < VD + VFP + VS);
    exp_rgb = pix_colour(h, v);
    e = push_v & ~mprev;
    mprev = push_v;
    if (e[2]) mdx[msel] = !mdx[msel];
    if (e[3]) mdy[msel] = !mdy[msel];
    if (tick && h == 0 && v == VD && !mpaused) begin
      for (int i = 0; i < NO; i++) begin
        p = mx[i]; d = mdx[i]; move_axis(p, d, HD); mx[i] = p; mdx[i] = d;
        p = my[i]; d = mdy[i]; move_axis(p, d, VD); my[i] = p; mdy[i] = d;
      end
    end
    if (e[0]) mpaused = !mpaused;
    if (e[1]) msel = (msel + 1) % NO;
    k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, push);
    #1;
    checks++;
    if (hsync !== exp_hs || vsync !== exp_vs || rgb !== exp_rgb) begin
      errors++;
      $display("FAIL scoreboard k=%0d: got hs=%b vs=%b rgb=%b, expected hs=%b vs=%b rgb=%b",
               k, hsync, vsync, rgb, exp_hs, exp_vs, exp_rgb);
    end
    if (!rst && k >= 1 && k <= FRAME) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic wait_state(input int pix, input int phase, input string name);
    int guard = 0;
    while (!((k % CD) == phase && ((k / CD) % (HT * VT)) == pix) && guard < FRAME + 4) begin
      step();
      guard++;
    end
    if (guard >= FRAME + 4) begin
      checks++;
      errors++;
      $display("FAIL %s: raster position not reached, got k=%0d, expected pixel %0d", name, k, pix);
    end
  endtask

  // Probes are relative to the last reset and must be in raster order.
  task automatic apply_probe(input probe_t p, input string tag);
    run_to((p.v * HT + p.h) * CD + 1);
    check($sformatf("%s_hs(%0d,%0d)", tag, p.h, p.v), 32'(hsync), 32'(p.hs));
    check($sformatf("%s_vs(%0d,%0d)", tag, p.h, p.v), 32'(vsync), 32'(p.vs));
    check($sformatf("%s_rgb(%0d,%0d)", tag, p.h, p.v), 32'(rgb), 32'(p.rgb));
  endtask

  task automatic press(input int b);
    push[b] = 1'b1;
    step();
    step();
    push[b] = 1'b0;
    step();
    step();
  endtask

  probe_t probes[13];
  probe_t rst_probes[3];

  initial begin
    probes[0]  = '{0, 0, 1'b1, 1'b1, 3'b000};
    probes[1]  = '{73, 5, 1'b1, 1'b1, 3'b000};
    probes[2]  = '{74, 5, 1'b0, 1'b1, 3'b000};
    probes[3]  = '{77, 5, 1'b0, 1'b1, 3'b000};
    probes[4]  = '{78, 5, 1'b1, 1'b1, 3'b000};
    probes[5]  = '{32, 32, 1'b1, 1'b1, 3'b111};
    probes[6]  = '{31, 35, 1'b1, 1'b1, 3'b000};
    probes[7]  = '{39, 39, 1'b1, 1'b1, 3'b111};
    probes[8]  = '{40, 39, 1'b1, 1'b1, 3'b000};
    probes[9]  = '{35, 40, 1'b1, 1'b1, 3'b000};
    probes[10] = '{10, 41, 1'b1, 1'b0, 3'b000};
    probes[11] = '{10, 42, 1'b1, 1'b0, 3'b000};
    probes[12] = '{10, 43, 1'b1, 1'b1, 3'b000};
    rst_probes[0] = '{0, 0, 1'b1, 1'b1, 3'b000};
    rst_probes[1] = '{35, 35, 1'b1, 1'b1, 3'b111};
    rst_probes[2] = '{40, 35, 1'b1, 1'b1, 3'b000};

    model_reset();
    rst = 1'b1;
    step();
    check("reset_hsync", 32'(hsync), 32'd1);
    check("reset_vsync", 32'(vsync), 32'd1);
    check("reset_rgb", 32'(rgb), 32'd0);
    step();
    step();
    rst = 1'b0;

    // First frame: reset image and sync placement.
    for (int i = 0; i < 13; i++) apply_probe(probes[i], "frame1");
    run_to(FRAME + 1);
    check("hsync_low_clks_per_frame", 32'(hs_low), 32'(VT * HS * CD));
    check("vsync_low_clks_per_frame", 32'(vs_low), 32'(VS * HT * CD));

    // Four selects wrap back to sprite 0.
    for (int i = 0; i < 4; i++) press(1);

    // Y flip arriving on the very frame-tick cycle must steer that move.
    wait_state(VD * HT, CD - 1, "frame_tick_coincide");
    push[3] = 1'b1;
    step();
    push[3] = 1'b0;
    step();

    // Held select advances once only.
    push[1] = 1'b1;
    repeat (1000) step();
    push[1] = 1'b0;
    step();

    // After four moves sprites 0 and 2 overlap; pause freezes them, Y flip while paused.
    run_to(4 * FRAME + 10);
    press(0);
    run_to(k + 2 * FRAME);
    press(3);
    run_to(k + FRAME);
    press(0);
    run_to(k + FRAME);

    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        push[b] = ~push[b];
      end
      step();
    end
    push = 4'b0000;
    step();

    // Reset in the middle of the visible area.
    wait_state(20 * HT, 0, "mid_frame_reset");
    rst = 1'b1;
    step();
    check("midrst_hsync", 32'(hsync), 32'd1);
    check("midrst_vsync", 32'(vsync), 32'd1);
    check("midrst_rgb", 32'(rgb), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply_probe(rst_probes[i], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
